// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Sequencer and two-way arbiter for the single-port, synchronous-read data
// memory.
//
// A CPU load takes two cycles. The first cycle issues the read and stalls the
// pipeline. The second cycle returns the data combinationally from the memory.
// A CPU store completes in a single cycle.
//
// A debug/loader requester shares the memory port with the CPU. It wins when
// the CPU is idle. It also wins once it has lost STARVE_LIMIT consecutive
// arbitrations against the CPU.
//
// Parameters:
//   ADDR_WIDTH   - data-memory address width
//   DATA_WIDTH   - data word width
//   STARVE_LIMIT - consecutive lost arbitrations before debug is forced through
//                  (0 gives debug absolute priority)
//
// Ports:
//   clk, reset     - clock; synchronous active-low reset
//   cpu_req/we     - MEM-stage access request and store flag
//   cpu_addr/wdata - CPU address and store data
//   cpu_rdata      - CPU load data (live in CPU_RD, held afterwards)
//   cpu_stall      - freezes the front of the pipeline this cycle
//   dbg_valid/we   - debug request valid and write flag
//   dbg_addr/wdata - debug address and write data
//   dbg_ready      - debug request accepted this cycle
//   dbg_rvalid     - one-cycle pulse with debug read data
//   dbg_rdata      - debug read data (live in DBG_RD, held afterwards)
//   mem_*          - single memory port; mem_rdata valid the cycle after a read
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  starve_cnt;
    logic [CNT_WIDTH-1:0]  starve_cnt_next;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_next;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_next;
    logic                  dbg_win;
    logic                  cpu_win;

    // Arbitration is only meaningful in IDLE. The read-data cycles never
    // grant anything, so both wins are qualified by the state.
    always_comb begin
        dbg_win = (state == IDLE) && dbg_valid && (!cpu_req || (starve_cnt == CNT_MAX));
        cpu_win = (state == IDLE) && cpu_req && !dbg_win;
    end

    // Control state and the two read-data holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state       <= state_next;
            starve_cnt  <= starve_cnt_next;
            cpu_rdata_q <= cpu_rdata_next;
            dbg_rdata_q <= dbg_rdata_next;
        end
    end

    // Next-state and output decode.
    // In the read cycles, cpu_stall depends only on state and cpu_req, so
    // there is no path from mem_rdata to the stall.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        cpu_rdata_next  = cpu_rdata_q;
        dbg_rdata_next  = dbg_rdata_q;
        cpu_rdata       = cpu_rdata_q;
        dbg_rdata       = dbg_rdata_q;
        cpu_stall       = 1'b0;
        dbg_ready       = 1'b0;
        dbg_rvalid      = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        case (state)
            IDLE: begin
                if (dbg_win) begin
                    dbg_ready       = 1'b1;
                    mem_en          = 1'b1;
                    mem_we          = dbg_we;
                    mem_addr        = dbg_addr;
                    mem_wdata       = dbg_wdata;
                    cpu_stall       = cpu_req;
                    starve_cnt_next = '0;
                    if (!dbg_we) begin
                        state_next = DBG_RD;
                    end
                end else if (cpu_win) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    if (!cpu_we) begin
                        cpu_stall  = 1'b1;
                        state_next = CPU_RD;
                    end
                    if (dbg_valid && (starve_cnt != CNT_MAX)) begin
                        starve_cnt_next = starve_cnt + 1'b1;
                    end
                end
            end
            CPU_RD: begin
                // cpu_req is still high here for the same load; it must not
                // be re-issued.
                cpu_rdata      = mem_rdata;
                cpu_rdata_next = mem_rdata;
                state_next     = IDLE;
            end
            DBG_RD: begin
                dbg_rvalid     = 1'b1;
                dbg_rdata      = mem_rdata;
                dbg_rdata_next = mem_rdata;
                cpu_stall      = cpu_req;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A withdrawn debug request resets the starvation history.
        if (!dbg_valid) begin
            starve_cnt_next = '0;
        end

        // While reset is held, every output is forced low.
        if (!reset) begin
            cpu_rdata  = '0;
            dbg_rdata  = '0;
            cpu_stall  = 1'b0;
            dbg_ready  = 1'b0;
            dbg_rvalid = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Testbench for dmem_arbiter.
//
// The main instance uses STARVE_LIMIT=4 and is attached to a behavioural
// synchronous-read memory. Each cycle, its outputs are compared with a
// transaction-level model. That model tracks which read is outstanding, how
// many arbitrations debug has lost, and an independent copy of memory.
//
// A second instance uses STARVE_LIMIT=0 and covers the debug-priority
// corner case.
module tb_dmem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_valid = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_ready;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // Signals for the STARVE_LIMIT=0 instance.
    logic          z_cpu_req = 1'b0;
    logic          z_cpu_we = 1'b0;
    logic [AW-1:0] z_cpu_addr = '0;
    logic [DW-1:0] z_cpu_wdata = '0;
    logic          z_dbg_valid = 1'b0;
    logic          z_dbg_we = 1'b0;
    logic [AW-1:0] z_dbg_addr = '0;
    logic [DW-1:0] z_dbg_wdata = '0;
    logic [DW-1:0] z_mem_rdata = '0;
    logic [DW-1:0] z_cpu_rdata;
    logic          z_cpu_stall;
    logic          z_dbg_ready;
    logic          z_dbg_rvalid;
    logic [DW-1:0] z_dbg_rdata;
    logic          z_mem_en;
    logic          z_mem_we;
    logic [AW-1:0] z_mem_addr;
    logic [DW-1:0] z_mem_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] sram    [0:255];
    bit            m_cpu_rd_pend = 1'b0;
    bit            m_dbg_rd_pend = 1'b0;
    logic [AW-1:0] m_cpu_rd_addr = '0;
    logic [AW-1:0] m_dbg_rd_addr = '0;
    logic [DW-1:0] m_cpu_hold = '0;
    logic [DW-1:0] m_dbg_hold = '0;
    int            m_losses = 0;
    bit            last_cpu_done = 1'b0;
    bit            last_dbg_accepted = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut_zero (
        .clk(clk), .reset(reset),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .dbg_valid(z_dbg_valid), .dbg_ready(z_dbg_ready), .dbg_we(z_dbg_we),
        .dbg_addr(z_dbg_addr), .dbg_wdata(z_dbg_wdata),
        .dbg_rvalid(z_dbg_rvalid), .dbg_rdata(z_dbg_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    // Single-port synchronous-read memory driven by the main instance.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and checks every output against the model.
    // It then advances the model to the state after the next rising edge.
    task automatic apply_stimulus(input logic rst_n, input logic c_req, input logic c_we,
                                  input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wdata,
                                  input logic d_valid, input logic d_we,
                                  input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wdata);
        logic          e_stall, e_ready, e_rvalid, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_cpu_rdata, e_dbg_rdata;
        bit            debug_turn, cpu_turn;
        @(negedge clk);
        reset = rst_n; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        dbg_valid = d_valid; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
        #1;
        e_stall = 0; e_ready = 0; e_rvalid = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_cpu_rdata = m_cpu_hold; e_dbg_rdata = m_dbg_hold;
        debug_turn = 0; cpu_turn = 0;
        if (!rst_n) begin
            e_cpu_rdata = '0; e_dbg_rdata = '0;
        end else if (m_cpu_rd_pend) begin
            e_cpu_rdata = ref_mem[m_cpu_rd_addr];
        end else if (m_dbg_rd_pend) begin
            e_rvalid = 1; e_dbg_rdata = ref_mem[m_dbg_rd_addr]; e_stall = c_req;
        end else begin
            debug_turn = d_valid && (!c_req || m_losses >= LIM);
            cpu_turn   = c_req && !debug_turn;
            if (debug_turn) begin
                e_ready = 1; e_en = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
                e_stall = c_req;
            end else if (cpu_turn) begin
                e_en = 1; e_we = c_we; e_addr = c_addr; e_wdata = c_wdata; e_stall = !c_we;
            end
        end
        check_output("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        check_output("dbg_ready", 32'(dbg_ready), 32'(e_ready));
        check_output("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rvalid));
        check_output("mem_en", 32'(mem_en), 32'(e_en));
        check_output("mem_we", 32'(mem_we), 32'(e_we));
        check_output("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
        check_output("dbg_rdata", 32'(dbg_rdata), 32'(e_dbg_rdata));
        if (e_en || !rst_n) check_output("mem_addr", 32'(mem_addr), 32'(e_addr));
        if ((e_en && e_we) || !rst_n) check_output("mem_wdata", 32'(mem_wdata), 32'(e_wdata));

        last_cpu_done = 0;
        last_dbg_accepted = 0;
        if (!rst_n) begin
            m_cpu_rd_pend = 0; m_dbg_rd_pend = 0; m_losses = 0;
            m_cpu_hold = '0; m_dbg_hold = '0;
        end else if (m_cpu_rd_pend) begin
            m_cpu_hold = ref_mem[m_cpu_rd_addr];
            m_cpu_rd_pend = 0;
            last_cpu_done = 1;
        end else if (m_dbg_rd_pend) begin
            m_dbg_hold = ref_mem[m_dbg_rd_addr];
            m_dbg_rd_pend = 0;
        end else if (debug_turn) begin
            m_losses = 0;
            last_dbg_accepted = 1;
            if (d_we) ref_mem[d_addr] = d_wdata;
            else begin m_dbg_rd_pend = 1; m_dbg_rd_addr = d_addr; end
        end else if (cpu_turn) begin
            if (d_valid) m_losses = (m_losses + 1 > LIM) ? LIM : m_losses + 1;
            if (c_we) begin
                ref_mem[c_addr] = c_wdata;
                last_cpu_done = 1;
            end else begin
                m_cpu_rd_pend = 1; m_cpu_rd_addr = c_addr;
            end
        end
        if (!d_valid) m_losses = 0;
    endtask

    initial begin
        bit            r_cpu_out, r_dbg_out, r_rst_n;
        logic          r_cpu_we, r_dbg_we;
        logic [AW-1:0] r_cpu_addr, r_dbg_addr;
        logic [DW-1:0] r_cpu_wdata, r_dbg_wdata;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            sram[i]    = '0;
        end

        // Reset: everything forced low.
        apply_stimulus(0, 1, 1, 8'h01, 16'h1111, 1, 1, 8'h02, 16'h2222);
        apply_stimulus(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("reset_cpu_stall", 32'(cpu_stall), 32'd0);

        // CPU only: store then load.
        apply_stimulus(1, 1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 16'h0000);
        check_output("store_no_stall", 32'(cpu_stall), 32'd0);
        apply_stimulus(1, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("load_stall", 32'(cpu_stall), 32'd1);
        apply_stimulus(1, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("load_data", 32'(cpu_rdata), 32'h1234);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // Debug only: write then read.
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'hBEEF);
        check_output("dbg_write_ready", 32'(dbg_ready), 32'd1);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("dbg_read_rvalid", 32'(dbg_rvalid), 32'd1);
        check_output("dbg_read_data", 32'(dbg_rdata), 32'hBEEF);

        // Contention with stores: debug wins the fifth arbitration.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 1, 1, AW'(i), DW'(16'h0A00 + i), 1, 1, 8'h30, 16'h5555);
            check_output("contend_ready", 32'(dbg_ready), 32'(i == 4));
            check_output("contend_stall", 32'(cpu_stall), 32'(i == 4));
        end
        apply_stimulus(1, 1, 1, 8'h04, 16'h0A04, 1, 1, 8'h31, 16'h6666);
        check_output("starve_cleared", 32'(dbg_ready), 32'd0);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h31, 16'h6666);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // Load and debug arrive together.
        apply_stimulus(1, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
        check_output("ld_dbg_cpu_wins", 32'(dbg_ready), 32'd0);
        apply_stimulus(1, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
        check_output("ld_dbg_cpurd_noready", 32'(dbg_ready), 32'd0);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
        check_output("ld_dbg_granted", 32'(dbg_ready), 32'd1);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // Reset during CPU_RD, then during DBG_RD.
        apply_stimulus(1, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        apply_stimulus(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("rst_mid_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check_output("rst_mid_mem_en", 32'(mem_en), 32'd0);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
        apply_stimulus(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        apply_stimulus(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check_output("rst_mid_no_rvalid", 32'(dbg_rvalid), 32'd0);

        // STARVE_LIMIT=0: debug always wins against a CPU store.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            z_cpu_req = 1; z_cpu_we = 1; z_cpu_addr = AW'(i); z_cpu_wdata = DW'(i);
            z_dbg_valid = 1; z_dbg_we = 1; z_dbg_addr = AW'(8'h40 + i); z_dbg_wdata = DW'(16'hC0 + i);
            #1;
            check_output("zero_limit_ready", 32'(z_dbg_ready), 32'd1);
            check_output("zero_limit_stall", 32'(z_cpu_stall), 32'd1);
        end
        @(negedge clk);
        z_cpu_req = 0; z_dbg_valid = 0;

        // Randomized traffic; requests are held until they complete.
        r_cpu_out = 0; r_dbg_out = 0;
        r_cpu_we = 0; r_dbg_we = 0; r_cpu_addr = '0; r_dbg_addr = '0;
        r_cpu_wdata = '0; r_dbg_wdata = '0;
        for (int n = 0; n < 800; n++) begin
            if (!r_cpu_out && $urandom_range(0, 99) < 60) begin
                r_cpu_out = 1;
                r_cpu_we = 1'($urandom_range(0, 1));
                r_cpu_addr = AW'($urandom_range(0, 15));
                r_cpu_wdata = DW'($urandom);
            end
            if (!r_dbg_out && $urandom_range(0, 99) < 50) begin
                r_dbg_out = 1;
                r_dbg_we = 1'($urandom_range(0, 1));
                r_dbg_addr = AW'($urandom_range(0, 15));
                r_dbg_wdata = DW'($urandom);
            end
            r_rst_n = ($urandom_range(0, 59) != 0);
            apply_stimulus(r_rst_n, r_cpu_out, r_cpu_we, r_cpu_addr, r_cpu_wdata,
                           r_dbg_out, r_dbg_we, r_dbg_addr, r_dbg_wdata);
            if (!r_rst_n) begin
                r_cpu_out = 0; r_dbg_out = 0;
            end else begin
                if (last_cpu_done) r_cpu_out = 0;
                if (last_dbg_accepted) r_dbg_out = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
